// File: rtl/mem_line_adapter_if.sv
// Request/response and word-RAM signals of the line adapter, bundled for the
// adapter (slave) and its environment (master: cache port plus RAM).
interface mem_line_adapter_if #(
    parameter int ADDR_BITS = 17
);
    localparam int WORD_ADDR_BITS = ADDR_BITS - 2;

    logic [ADDR_BITS-1:0]      req_addr;
    logic                      req_valid;
    logic                      req_wr;
    logic [127:0]              req_wr_data;
    logic [127:0]              rd_data;
    logic                      req_ready;
    logic [WORD_ADDR_BITS-1:0] ram_addr;
    logic                      ram_en;
    logic                      ram_we;
    logic [31:0]               ram_wdata;
    logic [31:0]               ram_rdata;

    modport slave (
        input  req_addr, req_valid, req_wr, req_wr_data, ram_rdata,
        output rd_data, req_ready, ram_addr, ram_en, ram_we, ram_wdata
    );

    modport master (
        output req_addr, req_valid, req_wr, req_wr_data, ram_rdata,
        input  rd_data, req_ready, ram_addr, ram_en, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_line_adapter.sv
// Splits one 128-bit line request into four 32-bit beats on a synchronous
// word RAM with fixed read latency, reassembling read lines into rd_data.
module mem_line_adapter #(
    parameter int RD_LATENCY     = 1,
    parameter int ADDR_BITS      = 17,
    parameter int WORD_ADDR_BITS = ADDR_BITS - 2
) (
    input logic              clk,
    input logic              rst,
    mem_line_adapter_if.slave bus
);
    localparam int LINE_BITS = ADDR_BITS - 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_ISSUE,
        S_READ_WAIT,
        S_RESP
    } state_e;

    state_e                    state_q;
    logic [LINE_BITS-1:0]      line_q;
    logic [1:0]                beat_q;
    logic [1:0]                beat_d;
    logic [127:0]              wr_data_q;
    logic [127:0]              rd_data_q;
    logic [RD_LATENCY-1:0]     tag_vld_q;
    logic [1:0]                tag_idx_q [RD_LATENCY];
    logic                      req_ready_q;
    logic                      ram_en_q;
    logic                      ram_we_q;
    logic [WORD_ADDR_BITS-1:0] ram_addr_q;
    logic [31:0]               ram_wdata_q;
    logic                      tag_out_vld;
    logic [1:0]                tag_out_idx;
    logic                      unused_low_addr;

    assign beat_d          = beat_q + 2'd1;
    assign tag_out_vld     = tag_vld_q[RD_LATENCY-1];
    assign tag_out_idx     = tag_idx_q[RD_LATENCY-1];
    assign unused_low_addr = ^bus.req_addr[3:0];

    // NOTE: every register below, including the wide line buffers and the tag
    // pipeline, is cleared asynchronously and only ever updated with <=, so
    // all readers in the same edge see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            line_q      <= '0;
            beat_q      <= '0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
            tag_vld_q   <= '0;
            req_ready_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) tag_idx_q[i] <= '0;
        end else begin
            // Tag enters the pipeline in the cycle its read beat is on the bus.
            tag_vld_q[0] <= (state_q == S_READ_ISSUE);
            tag_idx_q[0] <= beat_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
            if (tag_out_vld) rd_data_q[32*tag_out_idx +: 32] <= bus.ram_rdata;

            req_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        line_q      <= bus.req_addr[ADDR_BITS-1:4];
                        wr_data_q   <= bus.req_wr_data;
                        beat_q      <= 2'd0;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= bus.req_wr;
                        ram_addr_q  <= {bus.req_addr[ADDR_BITS-1:4], 2'd0};
                        ram_wdata_q <= bus.req_wr_data[31:0];
                        state_q     <= bus.req_wr ? S_WRITE : S_READ_ISSUE;
                    end
                end
                S_WRITE, S_READ_ISSUE: begin
                    if (beat_q == 2'd3) begin
                        ram_en_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        if (state_q == S_WRITE) begin
                            req_ready_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            state_q <= S_READ_WAIT;
                        end
                    end else begin
                        beat_q      <= beat_d;
                        ram_addr_q  <= {line_q, beat_d};
                        ram_wdata_q <= wr_data_q[32*beat_d +: 32];
                    end
                end
                S_READ_WAIT: begin
                    if (tag_out_vld && tag_out_idx == 2'd3) begin
                        req_ready_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.req_ready = req_ready_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_mem_line_adapter.sv
// Drives two adapters (read latency 1 and 3) with identical requests and
// checks beats, timing and assembled lines against a line-level memory model.
module tb_mem_line_adapter;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   bad_we = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_line_adapter_if #(.ADDR_BITS(17)) b1 ();
    mem_line_adapter_if #(.ADDR_BITS(17)) b3 ();

    mem_line_adapter #(.RD_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    mem_line_adapter #(.RD_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

    // Word RAMs seen by each adapter, with their read latency.
    logic [31:0] ram1 [32768];
    logic [31:0] ram3 [32768];
    logic [31:0] rp1;
    logic [31:0] rp3 [3];

    always @(posedge clk) begin
        if (b1.ram_en && b1.ram_we) ram1[b1.ram_addr] <= b1.ram_wdata;
        if (b3.ram_en && b3.ram_we) ram3[b3.ram_addr] <= b3.ram_wdata;
        rp1    <= ram1[b1.ram_addr];
        rp3[0] <= ram3[b3.ram_addr];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign b1.ram_rdata = rp1;
    assign b3.ram_rdata = rp3[2];

    typedef struct {
        int          cyc;
        logic        we;
        logic [14:0] addr;
        logic [31:0] wdata;
    } beat_t;

    beat_t beats1[$], beats3[$];
    int    rdy1[$], rdy3[$];

    always @(negedge clk) begin : mon
        beat_t b;
        if (b1.ram_en) begin
            b.cyc = cyc; b.we = b1.ram_we; b.addr = b1.ram_addr; b.wdata = b1.ram_wdata;
            beats1.push_back(b);
        end
        if (b3.ram_en) begin
            b.cyc = cyc; b.we = b3.ram_we; b.addr = b3.ram_addr; b.wdata = b3.ram_wdata;
            beats3.push_back(b);
        end
        if (b1.req_ready) rdy1.push_back(cyc);
        if (b3.req_ready) rdy3.push_back(cyc);
        if ((b1.ram_we && !b1.ram_en) || (b3.ram_we && !b3.ram_en)) bad_we++;
    end

    // Reference: memory contents as whole words, plus the line rd_data must show.
    logic [31:0]  model_mem [int];
    logic [127:0] exp_rd = '0;

    function automatic int word_key(input logic [16:0] a, input int k);
        logic [14:0] w;
        w = {a[16:4], 2'(k)};
        return int'(w);
    endfunction

    function automatic logic [127:0] model_line(input logic [16:0] a);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            if (model_mem.exists(word_key(a, k))) r[32*k +: 32] = model_mem[word_key(a, k)];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        b1.req_valid = v;
        b3.req_valid = v;
    endtask

    task automatic set_req(input logic v, input logic wr, input logic [16:0] a, input logic [127:0] d);
        set_valid(v);
        b1.req_wr = wr;  b1.req_addr = a;  b1.req_wr_data = d;
        b3.req_wr = wr;  b3.req_addr = a;  b3.req_wr_data = d;
    endtask

    task automatic clear_logs();
        beats1.delete(); beats3.delete(); rdy1.delete(); rdy3.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_L1_rd"},    b1.rd_data,   '0);
        check({tag, "_L1_rdy"},   b1.req_ready, '0);
        check({tag, "_L1_en"},    b1.ram_en,    '0);
        check({tag, "_L1_we"},    b1.ram_we,    '0);
        check({tag, "_L1_addr"},  b1.ram_addr,  '0);
        check({tag, "_L1_wdata"}, b1.ram_wdata, '0);
        check({tag, "_L3_rd"},    b3.rd_data,   '0);
        check({tag, "_L3_rdy"},   b3.req_ready, '0);
        check({tag, "_L3_en"},    b3.ram_en,    '0);
        check({tag, "_L3_we"},    b3.ram_we,    '0);
        check({tag, "_L3_addr"},  b3.ram_addr,  '0);
        check({tag, "_L3_wdata"}, b3.ram_wdata, '0);
    endtask

    task automatic check_txn(input int lat, input beat_t bq[$], input int rq[$],
                             input logic [127:0] rd, input int t0, input logic wr,
                             input logic [16:0] a, input logic [127:0] d);
        string p;
        p = $sformatf("L%0d", lat);
        check({p, "_ready_cnt"}, rq.size(), 1);
        if (rq.size() > 0) check({p, "_ready_cyc"}, rq[0] - t0, wr ? 5 : 5 + lat);
        check({p, "_beat_cnt"}, bq.size(), 4);
        for (int k = 0; k < 4 && k < bq.size(); k++) begin
            check($sformatf("%s_beat%0d_cyc", p, k), bq[k].cyc - t0, 1 + k);
            check($sformatf("%s_beat%0d_addr", p, k), bq[k].addr, {a[16:4], 2'(k)});
            check($sformatf("%s_beat%0d_we", p, k), bq[k].we, wr);
            if (wr) check($sformatf("%s_beat%0d_wdata", p, k), bq[k].wdata, d[32*k +: 32]);
        end
        check({p, "_rd_data"}, rd, exp_rd);
    endtask

    // Issues one request at the current cycle (cycle 0), holds req_valid for
    // 'hold' cycles, and returns in the cycle after the later completion pulse.
    task automatic do_req(input logic wr, input logic [16:0] a, input logic [127:0] d,
                          input int hold, input logic keep);
        int t0;
        int n;
        clear_logs();
        set_req(1'b1, wr, a, d);
        t0 = cyc;
        n  = 0;
        if (!wr) exp_rd = model_line(a);
        while (!(rdy1.size() > 0 && rdy3.size() > 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n >= hold && !(rdy1.size() > 0 && rdy3.size() > 0)) set_valid(1'b0);
        end
        set_valid(keep);
        check_txn(1, beats1, rdy1, b1.rd_data, t0, wr, a, d);
        check_txn(3, beats3, rdy3, b3.rd_data, t0, wr, a, d);
        if (wr) for (int k = 0; k < 4; k++) model_mem[word_key(a, k)] = d[32*k +: 32];
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] TP_DATA = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [127:0] da, db;
        logic [12:0]  pool [8];
        bit           written [8];
        int           t0;

        rst = 1'b0;
        set_req(1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed line write, then a back-to-back read with nonzero low bits.
        do_req(1'b1, 17'h00120, TP_DATA, 1, 1'b0);
        do_req(1'b0, 17'h0012C, '0, 1, 1'b0);
        check("tp_read_L1", b1.rd_data, TP_DATA);
        check("tp_read_L3", b3.rd_data, TP_DATA);

        // req_valid left high one cycle past completion: exactly one more request.
        da = rand_line();
        do_req(1'b1, 17'h00340, da, 20, 1'b1);
        do_req(1'b1, 17'h00340, da, 1, 1'b0);
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        check("extra_beats_L1", beats1.size(), 0);
        check("extra_beats_L3", beats3.size(), 0);
        check("extra_ready_L1", rdy1.size(), 0);
        check("extra_ready_L3", rdy3.size(), 0);

        // req_valid dropped in cycle 2 of a read.
        do_req(1'b0, 17'h00340, '0, 2, 1'b0);

        // Reset in cycle 3 of a write: only beats 0-1 reach the RAM.
        da = rand_line();
        db = rand_line();
        do_req(1'b1, 17'h005A0, da, 1, 1'b0);
        clear_logs();
        set_req(1'b1, 1'b1, 17'h005A0, db);
        t0 = cyc;
        @(posedge clk); #1;
        set_valid(1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_cycle", cyc - t0, 3);
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        check("rst_beats_L1", beats1.size(), 2);
        check("rst_beats_L3", beats3.size(), 2);
        for (int k = 0; k < 2; k++) model_mem[word_key(17'h005A0, k)] = db[32*k +: 32];
        exp_rd = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 17'h005A0, '0, 1, 1'b0);

        // Top line of the address space.
        da = rand_line();
        do_req(1'b1, 17'h1FFF0, da, 1, 1'b0);
        do_req(1'b0, 17'h1FFF5, '0, 1, 1'b0);
        check("top_L1", b1.rd_data, da);

        // Random mix over a small pool of lines so reads hit written data.
        for (int i = 0; i < 8; i++) begin
            pool[i]    = 13'($urandom_range(0, 8191));
            written[i] = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            int   idx;
            logic wr;
            idx = $urandom_range(0, 7);
            wr  = !written[idx] || ($urandom_range(0, 1) == 1);
            written[idx] = 1'b1;
            do_req(wr, {pool[idx], 4'($urandom)}, rand_line(), $urandom_range(1, 4), 1'b0);
        end

        check("we_without_en", bad_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/mem_line_adapter.md
# mem_line_adapter

Memory-side stage directly downstream of the unified data cache. Accepts one 128-bit line request (write-back or allocate) from the cache's memory port and performs it as four sequential 32-bit accesses to a synchronous single-port word RAM with a fixed read latency. Returns the assembled 128-bit line and a one-cycle completion pulse on `req_ready`.

## Interface
Parameters:
- `RD_LATENCY`, default 1: cycles from a read beat being presented on the RAM port to `ram_rdata` being valid. Legal range 1..4.
- `ADDR_BITS`, default 17: byte address width (128 KB).
- `WORD_ADDR_BITS`, default 15: derived, `ADDR_BITS-2`.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_addr` input 17: line byte address. Bits [3:0] ignored (line = 16 bytes).
- `req_valid` input 1: request present. Sampled only in IDLE.
- `req_wr` input 1: 1 = write line, 0 = read line.
- `req_wr_data` input 128: write line. Word k is bits [32k+31:32k].
- `rd_data` output 128: last read line, same word ordering.
- `req_ready` output 1: one-cycle completion pulse.
- `ram_addr` output 15: word address `{line_addr[16:4], beat[1:0]}`.
- `ram_en` output 1: RAM access strobe.
- `ram_we` output 1: RAM write strobe, only with `ram_en`.
- `ram_wdata` output 32: write word.
- `ram_rdata` input 32: read word, valid RD_LATENCY cycles after the read beat.

## Operation
- States: IDLE, WRITE, READ_ISSUE, READ_WAIT, RESP.
- IDLE: when `req_valid`=1, latch `req_addr[16:4]`, `req_wr` and `req_wr_data`, and clear the beat counter. Go to WRITE if `req_wr` is set, else READ_ISSUE.
- WRITE: drive beat k (k = 0..3) with `ram_en`=`ram_we`=1, `ram_wdata` = latched word k and `ram_addr` = {line, k}. After beat 3, go to RESP.
- READ_ISSUE: drive beat k with `ram_en`=1, `ram_we`=0. Push a tag into an RD_LATENCY-deep valid/index pipeline. After beat 3, go to READ_WAIT.
- Capture: when a pipeline tag emerges with index j, write `ram_rdata` into `rd_data` word j. Capture happens in both READ_ISSUE and READ_WAIT.
- READ_WAIT: leave for RESP in the cycle after word 3 is captured.
- RESP: `req_ready`=1 for exactly one cycle, then return to IDLE. No request is accepted in RESP.
- `rd_data` holds its value until it is overwritten word by word during the next read. Write requests never modify it. Words are updated in place, so `rd_data` is only guaranteed coherent while `req_ready`=1 and afterwards until the next read is accepted.
- `req_valid` is ignored outside IDLE. Dropping it mid-operation does not abort the operation.
- Requester rule: deassert `req_valid` in the cycle after `req_ready` unless it is issuing a new request. If still high, that cycle is treated as a new request.

## Timing
- All outputs are registered.
- Reset values: `req_ready`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `rd_data`=0, state=IDLE, valid pipeline cleared.
- Cycle numbering: cycle 0 is the cycle in which IDLE samples `req_valid`=1.
- Write: `ram_en` high in cycles 1–4 with beats 0–3; `req_ready` high in cycle 5. Next acceptance is possible in cycle 6.
- Read: `ram_en` high in cycles 1–4; word k is captured at the end of cycle 1+k+RD_LATENCY; `req_ready` high in cycle 5+RD_LATENCY (cycle 6 for RD_LATENCY=1).
- Back-to-back: minimum request spacing is 6 cycles for writes and 6+RD_LATENCY cycles for reads.
- `ram_en` is low in IDLE, READ_WAIT and RESP. `ram_we` never rises without `ram_en`.
- Reset asserted mid-operation: all outputs return to reset values immediately and in-flight read tags are discarded. RAM words already written are not rolled back. After reset release, the first edge with `req_valid`=1 starts a fresh request.
- Address wrap: line 0x1FFF0 uses word addresses 0x7FFC–0x7FFF. No carry into other lines.

## Test plan
- Write line: addr 0x00120, data {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000} -> RAM beats at 0x0048..0x004B with 0xAAAA0000..0xDDDD0003 in cycles 1–4, `req_ready` pulse in cycle 5, `rd_data` unchanged.
- Read line after the above, addr 0x0012C (low bits nonzero) -> addresses 0x0048..0x004B, `rd_data`=0xDDDD0003_CCCC0002_BBBB0001_AAAA0000, `req_ready` in cycle 6 (RD_LATENCY=1). Repeat with RD_LATENCY=3 -> `req_ready` in cycle 8.
- Back-to-back: write, then read accepted in the cycle after the write's `req_ready` -> no dropped or duplicated beats. `req_valid` held for one extra cycle after `req_ready` -> exactly one extra request executed.
- `req_valid` dropped in cycle 2 of a read -> all 4 beats still issued and `req_ready` still pulses.
- `rst` asserted in cycle 3 of a write -> outputs 0 immediately, only beats 0–1 present in RAM, next request completes normally.
- Top line 0x1FFF0 read/write -> word addresses 0x7FFC–0x7FFF, data round-trips intact.
